// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester: turns single-beat valid/ready commands into SETUP/ACCESS transfers.
// Returns read data or a timeout flag on a one-cycle response strobe.
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    // A zero timeout still needs a 1-bit counter so the logic stays well formed.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_accept;
    logic            w_timeout_hit;
    logic            w_done;
    logic            w_abort;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cnt_inc = r_wait_cnt + CW'(1);

    // PREADY on the limit edge wins over the timeout because it is checked first below.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY && (w_cnt_inc == TO_LIMIT);

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end else if (w_timeout_hit) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_SETUP) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_ACCESS && !PREADY && r_wait_cnt != CNT_MAX) begin
                r_wait_cnt <= w_cnt_inc;
            end
        end
    end

    // Bus controls are registered copies of the next state so they line up with r_state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            PSEL        <= (w_state_next != ST_IDLE);
            PENABLE     <= (w_state_next == ST_ACCESS);
            rsp_valid   <= w_done || w_abort;
            rsp_timeout <= w_abort;
            if (w_accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (w_done) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
            end else if (w_abort) begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with a wait-state APB completer model.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_master #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        to;
        logic [31:0] rd;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [256];
    int          tb_waits = 0;
    int          c_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Completer: PREADY rises after tb_waits ACCESS cycles; tb_waits < 0 never answers.
    always @(negedge PCLK) begin
        PRDATA = mem[PADDR];
        if (PRESETn && PSEL && PENABLE) begin
            if (tb_waits >= 0 && c_cnt == tb_waits) begin
                PREADY = 1'b1;
                if (PWRITE) mem[PADDR] = PWDATA;
            end else begin
                PREADY = 1'b0;
            end
            c_cnt++;
        end else begin
            c_cnt  = 0;
            PREADY = 1'b0;
        end
    end

    // Monitor: counts ACCESS cycles, watches bus stability, checks each response against the queue.
    int          acc_seen = 0;
    logic        unstable = 1'b0;
    logic [40:0] s_bus = '0;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acc_seen = 0;
            unstable = 1'b0;
        end else begin
            if (PSEL && !PENABLE) begin
                acc_seen = 0;
                unstable = 1'b0;
                s_bus    = {PADDR, PWRITE, PWDATA};
            end
            if (PSEL && PENABLE) begin
                acc_seen++;
                if ({PADDR, PWRITE, PWDATA} !== s_bus) unstable = 1'b1;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    expire("rsp_unexpected");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
                    chk("access_cycles", 64'(acc_seen), 64'(e.acc));
                    chk("bus_stable", 64'(unstable), 64'd0);
                    chk("psel_low_at_rsp", 64'({PSEL, PENABLE}), 64'd0);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic eto, input logic [31:0] erd, input int eacc,
                         output logic prev_rsp);
        int   guard;
        exp_t e;
        guard     = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (!cmd_ready) expire("accept");
        prev_rsp = rsp_valid;
        @(posedge PCLK);
        e.to  = eto;
        e.rd  = erd;
        e.acc = eacc;
        exp_q.push_back(e);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        if (exp_q.size() != 0) expire("response");
        @(negedge PCLK);
    endtask

    logic pr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        PRDATA    = 32'h0;
        #12;
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_bus", 64'({PWRITE, PADDR, PWDATA}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_timeout, rsp_rdata}), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Zero-wait write, then 3-wait read of the same location.
        tb_waits = 0;
        issue(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1, pr);
        wait_done();
        chk("mem_0x10", 64'(mem[8'h10]), 64'hDEADBEEF);
        tb_waits = 3;
        issue(1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 4, pr);
        wait_done();

        // Back-to-back: second accept lands in the response cycle of the first.
        tb_waits = 0;
        issue(1'b1, 8'h20, 32'h1, 1'b0, 32'h0, 1, pr);
        issue(1'b0, 8'h20, 32'h0, 1'b0, 32'h1, 1, pr);
        chk("b2b_prev_rsp", 64'(pr), 64'd1);
        chk("b2b_setup", 64'({PSEL, PENABLE}), 64'b10);
        wait_done();

        // Completer never answers: abort after 4 ACCESS cycles with zero data.
        tb_waits = -1;
        issue(1'b0, 8'h10, 32'h0, 1'b1, 32'h0, 4, pr);
        wait_done();
        chk("to_cmd_ready", 64'(cmd_ready), 64'd1);

        // PREADY on the limit edge completes normally.
        tb_waits = 0;
        issue(1'b1, 8'h30, 32'h5A5A5A5A, 1'b0, 32'h0, 1, pr);
        wait_done();
        tb_waits = 3;
        issue(1'b0, 8'h30, 32'h0, 1'b0, 32'h5A5A5A5A, 4, pr);
        wait_done();

        tb_waits = 2;
        issue(1'b1, 8'h40, 32'h12345678, 1'b0, 32'h0, 3, pr);
        wait_done();
        tb_waits = 1;
        issue(1'b0, 8'h40, 32'h0, 1'b0, 32'h12345678, 2, pr);
        wait_done();

        // Reset while waiting in ACCESS: outputs clear at once, no response.
        tb_waits = -1;
        issue(1'b1, 8'h55, 32'hCAFEF00D, 1'b1, 32'h0, 4, pr);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("pre_rst_access", 64'({PSEL, PENABLE}), 64'b11);
        #2;
        PRESETn = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_psel", 64'({PSEL, PENABLE}), 64'd0);
        chk("mid_rst_bus", 64'({PWRITE, PADDR, PWDATA}), 64'd0);
        chk("mid_rst_rsp", 64'({rsp_valid, rsp_timeout, rsp_rdata}), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("mem_0x55_untouched", 64'(mem[8'h55]), 64'd0);
        tb_waits = 0;
        issue(1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1, pr);
        wait_done();
        repeat (3) @(negedge PCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-beat read/write commands from a local valid/ready command port into APB SETUP/ACCESS transfers. It drives PSEL, PENABLE, PADDR, PWRITE and PWDATA toward one APB completer (our apb_design), and samples PREADY and PRDATA. It returns read data, or a timeout flag, on a one-cycle response strobe. It sits between test/controller logic and the APB bus, and is the initiator side of the APB interface.

## Interface
- ADDR_WIDTH, 8, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with PREADY low before abort. A value of 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  reset; asynchronous assert, active-low; one clock, asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  qualifies rsp_valid; transfer aborted without PREADY.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB completer ready.

## Operation
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Transitions:
  - IDLE -> SETUP on cmd_valid && cmd_ready.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE on PREADY=1 or on timeout; otherwise ACCESS holds.
- cmd_ready = (state == IDLE), decoded combinationally from the state register. There is no command buffering; commands presented outside IDLE wait.
- On accept, register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA.
  - These values stay stable through SETUP and all ACCESS cycles.
  - After completion they keep their last value.
- Completion with PREADY=1 in ACCESS:
  - Read: capture PRDATA into rsp_rdata.
  - Write: set rsp_rdata=0.
  - Set rsp_timeout=0 and rsp_valid=1 for exactly one cycle.
- Timeout:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle sampled with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, go to IDLE and pulse rsp_valid with rsp_timeout=1 and rsp_rdata=0.
  - Counter width is clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- PREADY is ignored outside ACCESS. PRDATA is sampled only on a read completion edge.
- All outputs except cmd_ready are registered.

## Timing
- Reset values while PRESETn=0: state=IDLE, and PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_timeout and the wait counter all 0. cmd_ready reads 1 (IDLE).
- Zero-wait transfer, with accept at edge 0:
  - SETUP is visible in cycle 1 and ACCESS in cycle 2.
  - PREADY is sampled high at edge 3.
  - rsp_valid is high in cycle 3, and cmd_ready is high again in cycle 3.
- Each wait state adds one ACCESS cycle. A back-to-back command accepted at edge 3 puts SETUP in cycle 4. Minimum period is 3 cycles per transfer.
- Timeout with TIMEOUT_CYCLES=N and PREADY held low: ACCESS lasts N cycles, and rsp_valid/rsp_timeout pulse in the cycle after the last ACCESS cycle.
- If PREADY rises on the same edge the counter reaches N, that transfer is a normal completion, not a timeout.
- Reset mid-transfer: everything returns to reset values immediately. No rsp_valid is generated for the aborted transfer.

## Test plan
- Zero-wait write: cmd_write=1, addr=0x10, wdata=0xDEADBEEF; completer holds PREADY=1 -> PSEL in cycles 1-2, PENABLE in cycle 2, one rsp_valid with rsp_timeout=0 and rsp_rdata=0, completer stores 0xDEADBEEF at 0x10.
- Read with 3 wait states: read from 0x10 -> ACCESS lasts 4 cycles with PADDR/PWRITE stable, and rsp_rdata=0xDEADBEEF.
- Back-to-back: cmd_valid held with write 0x20=0x1, then read 0x20 -> second SETUP in the cycle after the first rsp_valid, with no idle gap, and read returns 0x00000001.
- Timeout: TIMEOUT_CYCLES=4, PREADY tied 0 -> exactly 4 ACCESS cycles, then rsp_valid=1 with rsp_timeout=1 and rsp_rdata=0, and PSEL drops.
- PREADY on limit edge: TIMEOUT_CYCLES=4, PREADY rises on the 4th ACCESS cycle of a read returning 0x5A5A5A5A -> rsp_timeout=0, rsp_rdata=0x5A5A5A5A.
- Reset in ACCESS: PRESETn low during wait states -> PSEL, PENABLE and all outputs go to 0 asynchronously, no rsp_valid, and a new command after reset release completes normally.
